exec_trace_checker: RTL and testbench

// Synthesizable self-checking monitor of the core's retire stream against an expected trace ROM.

---
 rtl/exec_trace_checker.sv | 195 +++++++++++++++++++
 tb/tb_exec_trace_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_trace_checker.sv
// Retire-stream checker: compares each retired instruction against a table of expected
// entries and latches a pass/fail verdict with the failing entry and cause.
module exec_trace_checker #(
  parameter int EntryCount    = 16,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int RegIndexWidth = 5,
  parameter int TimeoutCycles = 100_000,
  // Flattened trace table, entry i at bits [i*EntryWidth +: EntryWidth]
  parameter logic [EntryCount*(2+2*AddressWidth+RegIndexWidth+DataWidth)-1:0] RomImage = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             retire_valid,
  input  logic [AddressWidth-1:0]          retire_pc,
  input  logic                             rd_we,
  input  logic [RegIndexWidth-1:0]         rd_index,
  input  logic [DataWidth-1:0]             rd_data,
  input  logic                             mem_we,
  input  logic [AddressWidth-1:0]          mem_address,
  input  logic [DataWidth-1:0]             mem_data,
  output logic                             done,
  output logic                             passed,
  output logic                             failed,
  output logic [$clog2(EntryCount+1)-1:0]  fail_entry,
  output logic [2:0]                       fail_cause
);

  localparam int EntryWidth    = 2 + 2*AddressWidth + RegIndexWidth + DataWidth;
  localparam int EntryIdxWidth = $clog2(EntryCount+1);
  localparam int TimerWidth    = $clog2(TimeoutCycles+1);

  localparam logic [1:0] KIND_PC    = 2'd0;
  localparam logic [1:0] KIND_REG   = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_END   = 2'd3;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_PC      = 3'd1;
  localparam logic [2:0] CAUSE_MISSING = 3'd2;
  localparam logic [2:0] CAUSE_DATA    = 3'd3;
  localparam logic [2:0] CAUSE_INDEX   = 3'd4;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd5;

  typedef struct packed {
    logic [1:0]               kind;
    logic [AddressWidth-1:0]  pc;
    logic [AddressWidth-1:0]  aux;
    logic [RegIndexWidth-1:0] index;
    logic [DataWidth-1:0]     value;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_PASS, ST_FAIL} state_t;

  state_t                   state_q, state_d;
  logic [EntryIdxWidth-1:0] entry_q, entry_d;
  logic [TimerWidth-1:0]    timer_q, timer_d;
  logic                     done_q, done_d;
  logic                     passed_q, passed_d;
  logic                     failed_q, failed_d;
  logic [EntryIdxWidth-1:0] fail_entry_q, fail_entry_d;
  logic [2:0]               fail_cause_q, fail_cause_d;

  entry_t                   cur_s;
  entry_t                   nxt_s;
  logic [2:0]               cause_s;
  logic                     last_s;

  // Out-of-range indices read as a plain pc-0 entry; callers never act on them.
  function automatic entry_t rom_read(input logic [EntryIdxWidth-1:0] idx);
    if (int'(idx) < EntryCount) begin
      rom_read = RomImage[int'(idx)*EntryWidth +: EntryWidth];
    end else begin
      rom_read = '0;
    end
  endfunction

  assign cur_s  = rom_read(entry_q);
  assign nxt_s  = rom_read(entry_q + EntryIdxWidth'(1));
  assign last_s = (entry_q == EntryIdxWidth'(EntryCount - 1));

  // Mismatch classification of the current retire, highest priority first
  always_comb begin
    cause_s = CAUSE_NONE;
    if (retire_pc != cur_s.pc) begin
      cause_s = CAUSE_PC;
    end else begin
      case (cur_s.kind)
        KIND_REG: begin
          if (!rd_we)                       cause_s = CAUSE_MISSING;
          else if (rd_index != cur_s.index) cause_s = CAUSE_INDEX;
          else if (rd_data != cur_s.value)  cause_s = CAUSE_DATA;
          else                              cause_s = CAUSE_NONE;
        end
        KIND_STORE: begin
          if (!mem_we)                        cause_s = CAUSE_MISSING;
          else if (mem_address != cur_s.aux)  cause_s = CAUSE_INDEX;
          else if (mem_data != cur_s.value)   cause_s = CAUSE_DATA;
          else                                cause_s = CAUSE_NONE;
        end
        default: cause_s = CAUSE_NONE;
      endcase
    end
  end

  // Next-state and verdict logic
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    timer_d      = timer_q;
    done_d       = done_q;
    passed_d     = passed_q;
    failed_d     = failed_q;
    fail_entry_d = fail_entry_q;
    fail_cause_d = fail_cause_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHECK;
          entry_d = '0;
          timer_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (cur_s.kind == KIND_END) begin
          state_d  = ST_PASS;
          done_d   = 1'b1;
          passed_d = 1'b1;
        end else if (retire_valid) begin
          timer_d = '0;
          if (cause_s != CAUSE_NONE) begin
            state_d      = ST_FAIL;
            done_d       = 1'b1;
            failed_d     = 1'b1;
            fail_entry_d = entry_q;
            fail_cause_d = cause_s;
          end else begin
            entry_d = entry_q + EntryIdxWidth'(1);
            if (last_s || (nxt_s.kind == KIND_END)) begin
              state_d  = ST_PASS;
              done_d   = 1'b1;
              passed_d = 1'b1;
            end else begin
              state_d = ST_CHECK;
            end
          end
        end else if (timer_q == TimerWidth'(TimeoutCycles - 1)) begin
          state_d      = ST_FAIL;
          done_d       = 1'b1;
          failed_d     = 1'b1;
          fail_entry_d = entry_q;
          fail_cause_d = CAUSE_TIMEOUT;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end
      ST_PASS: state_d = ST_PASS;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and verdict registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      entry_q      <= '0;
      timer_q      <= '0;
      done_q       <= 1'b0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      fail_entry_q <= '0;
      fail_cause_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      timer_q      <= timer_d;
      done_q       <= done_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      fail_entry_q <= fail_entry_d;
      fail_cause_q <= fail_cause_d;
    end
  end

  assign done       = done_q;
  assign passed     = passed_q;
  assign failed     = failed_q;
  assign fail_entry = fail_entry_q;
  assign fail_cause = fail_cause_q;

endmodule

// File: tb/tb_exec_trace_checker.sv
// Directed bench: four checker instances with different trace tables share one retire bus.
module tb_exec_trace_checker;

  localparam int EW = 103;

  // Table A: reg write then pc-only then end marker
  localparam logic [EW-1:0] A0 = {2'd1, 32'h0000_0000, 32'h0, 5'd2, 32'h0001_0000};
  localparam logic [EW-1:0] A1 = {2'd0, 32'h0000_0004, 32'h0, 5'd0, 32'h0};
  localparam logic [EW-1:0] A2 = {2'd3, 101'd0};
  localparam logic [EW-1:0] A3 = {2'd0, 101'd0};
  // Table B: one store then end marker
  localparam logic [EW-1:0] B0 = {2'd2, 32'h0000_000c, 32'h0000_fffc, 5'd0, 32'h0000_0008};
  localparam logic [EW-1:0] B1 = {2'd3, 101'd0};
  // Table C: two pc-only entries then end marker
  localparam logic [EW-1:0] C0 = {2'd0, 32'h0000_0000, 32'h0, 5'd0, 32'h0};
  localparam logic [EW-1:0] C1 = {2'd0, 32'h0000_0004, 32'h0, 5'd0, 32'h0};
  localparam logic [EW-1:0] C2 = {2'd3, 101'd0};
  // Table D: no end marker, finishes by exhausting the table
  localparam logic [EW-1:0] D0 = {2'd0, 32'h0000_0000, 32'h0, 5'd0, 32'h0};
  localparam logic [EW-1:0] D1 = {2'd1, 32'h0000_0004, 32'h0, 5'd1, 32'h0000_0005};
  localparam logic [EW-1:0] D2 = {2'd2, 32'h0000_0008, 32'h0000_0100, 5'd0, 32'h0000_0007};

  logic        clk, rst_n;
  logic        start_a, start_b, start_c, start_d;
  logic        retire_valid, rd_we, mem_we;
  logic [31:0] retire_pc, rd_data, mem_address, mem_data;
  logic [4:0]  rd_index;

  logic       done_a, passed_a, failed_a;
  logic [2:0] fail_entry_a, fail_cause_a;
  logic       done_b, passed_b, failed_b;
  logic [1:0] fail_entry_b;
  logic [2:0] fail_cause_b;
  logic       done_c, passed_c, failed_c;
  logic [1:0] fail_entry_c;
  logic [2:0] fail_cause_c;
  logic       done_d, passed_d, failed_d;
  logic [1:0] fail_entry_d;
  logic [2:0] fail_cause_d;

  int n_pass  = 0;
  int n_total = 0;

  exec_trace_checker #(.EntryCount(4), .TimeoutCycles(1000), .RomImage({A3, A2, A1, A0})) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .rd_we(rd_we), .rd_index(rd_index), .rd_data(rd_data), .mem_we(mem_we),
    .mem_address(mem_address), .mem_data(mem_data), .done(done_a), .passed(passed_a),
    .failed(failed_a), .fail_entry(fail_entry_a), .fail_cause(fail_cause_a));

  exec_trace_checker #(.EntryCount(2), .TimeoutCycles(1000), .RomImage({B1, B0})) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .rd_we(rd_we), .rd_index(rd_index), .rd_data(rd_data), .mem_we(mem_we),
    .mem_address(mem_address), .mem_data(mem_data), .done(done_b), .passed(passed_b),
    .failed(failed_b), .fail_entry(fail_entry_b), .fail_cause(fail_cause_b));

  exec_trace_checker #(.EntryCount(3), .TimeoutCycles(8), .RomImage({C2, C1, C0})) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .rd_we(rd_we), .rd_index(rd_index), .rd_data(rd_data), .mem_we(mem_we),
    .mem_address(mem_address), .mem_data(mem_data), .done(done_c), .passed(passed_c),
    .failed(failed_c), .fail_entry(fail_entry_c), .fail_cause(fail_cause_c));

  exec_trace_checker #(.EntryCount(3), .TimeoutCycles(1000), .RomImage({D2, D1, D0})) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .rd_we(rd_we), .rd_index(rd_index), .rd_data(rd_data), .mem_we(mem_we),
    .mem_address(mem_address), .mem_data(mem_data), .done(done_d), .passed(passed_d),
    .failed(failed_d), .fail_entry(fail_entry_d), .fail_cause(fail_cause_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic retire(input logic [31:0] pc, input logic rwe, input logic [4:0] ridx,
                        input logic [31:0] rdata, input logic mwe, input logic [31:0] maddr,
                        input logic [31:0] mdata);
    retire_valid = 1'b1;
    retire_pc    = pc;
    rd_we        = rwe;
    rd_index     = ridx;
    rd_data      = rdata;
    mem_we       = mwe;
    mem_address  = maddr;
    mem_data     = mdata;
    tick();
    retire_valid = 1'b0;
    rd_we        = 1'b0;
    mem_we       = 1'b0;
  endtask

  task automatic pulse_start(input int which);
    start_a = (which == 0);
    start_b = (which == 1);
    start_c = (which == 2);
    start_d = (which == 3);
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    start_d = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    retire_valid = 1'b0; rd_we = 1'b0; mem_we = 1'b0;
    retire_pc = 32'h0; rd_index = 5'd0; rd_data = 32'h0; mem_address = 32'h0; mem_data = 32'h0;
    #12;
    chk("reset done", {31'd0, done_a}, 32'd0);
    chk("reset passed", {31'd0, passed_a}, 32'd0);
    chk("reset failed", {31'd0, failed_a}, 32'd0);
    chk("reset fail_entry", {29'd0, fail_entry_a}, 32'd0);
    chk("reset fail_cause", {29'd0, fail_cause_a}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Idle ignores retires
    retire(32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("idle retire ignored", {31'd0, failed_a}, 32'd0);

    // Matching trace passes one cycle after the last retire
    pulse_start(0);
    retire(32'h0, 1'b1, 5'd2, 32'h0001_0000, 1'b0, 32'h0, 32'h0);
    chk("t1 mid passed", {31'd0, passed_a}, 32'd0);
    retire(32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("t1 passed", {31'd0, passed_a}, 32'd1);
    chk("t1 done", {31'd0, done_a}, 32'd1);
    chk("t1 failed", {31'd0, failed_a}, 32'd0);
    chk("t1 cause", {29'd0, fail_cause_a}, 32'd0);

    // Data mismatch
    do_reset();
    chk("t2 reset clears passed", {31'd0, passed_a}, 32'd0);
    pulse_start(0);
    retire(32'h0, 1'b1, 5'd2, 32'h0001_0004, 1'b0, 32'h0, 32'h0);
    chk("t2 failed", {31'd0, failed_a}, 32'd1);
    chk("t2 passed", {31'd0, passed_a}, 32'd0);
    chk("t2 done", {31'd0, done_a}, 32'd1);
    chk("t2 entry", {29'd0, fail_entry_a}, 32'd0);
    chk("t2 cause", {29'd0, fail_cause_a}, 32'd3);

    // pc mismatch outranks missing write
    do_reset();
    pulse_start(0);
    retire(32'h8, 1'b0, 5'd2, 32'h0001_0000, 1'b0, 32'h0, 32'h0);
    chk("pc cause", {29'd0, fail_cause_a}, 32'd1);

    // Index mismatch outranks data mismatch, reported at entry 1 after a good first retire
    do_reset();
    pulse_start(0);
    retire(32'h0, 1'b1, 5'd3, 32'h0001_0004, 1'b0, 32'h0, 32'h0);
    chk("index cause", {29'd0, fail_cause_a}, 32'd4);
    do_reset();
    pulse_start(0);
    retire(32'h0, 1'b1, 5'd2, 32'h0001_0000, 1'b0, 32'h0, 32'h0);
    retire(32'h8, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("entry1 fail_entry", {29'd0, fail_entry_a}, 32'd1);
    chk("entry1 cause", {29'd0, fail_cause_a}, 32'd1);

    // Store checks
    do_reset();
    pulse_start(1);
    retire(32'hc, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0000_fffc, 32'h8);
    chk("t3 missing store", {29'd0, fail_cause_b}, 32'd2);
    do_reset();
    pulse_start(1);
    retire(32'hc, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_fff8, 32'h8);
    chk("t3 address cause", {29'd0, fail_cause_b}, 32'd4);
    do_reset();
    pulse_start(1);
    retire(32'hc, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_fffc, 32'h8);
    chk("t3 store passed", {31'd0, passed_b}, 32'd1);

    // Timeout after 8 retire-free cycles
    do_reset();
    pulse_start(2);
    repeat (7) tick();
    chk("t4 no early timeout", {31'd0, failed_c}, 32'd0);
    tick();
    chk("t4 timeout failed", {31'd0, failed_c}, 32'd1);
    chk("t4 timeout cause", {29'd0, fail_cause_c}, 32'd5);
    chk("t4 timeout entry", {30'd0, fail_entry_c}, 32'd0);
    do_reset();
    pulse_start(2);
    repeat (7) tick();
    retire(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("t4 retire beats timeout", {31'd0, failed_c}, 32'd0);
    retire(32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("t4 proceeds to pass", {31'd0, passed_c}, 32'd1);

    // Table exhaustion without end marker; verdict holds afterwards
    do_reset();
    pulse_start(3);
    retire(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    retire(32'h4, 1'b1, 5'd1, 32'h5, 1'b0, 32'h0, 32'h0);
    chk("t5 not yet passed", {31'd0, passed_d}, 32'd0);
    retire(32'h8, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'h7);
    chk("t5 passed", {31'd0, passed_d}, 32'd1);
    retire(32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    retire(32'h77, 1'b1, 5'd3, 32'h1, 1'b0, 32'h0, 32'h0);
    chk("t5 passed holds", {31'd0, passed_d}, 32'd1);
    chk("t5 failed stays 0", {31'd0, failed_d}, 32'd0);

    // Asynchronous reset mid-check, then clean restart
    do_reset();
    pulse_start(0);
    retire(32'h0, 1'b1, 5'd2, 32'h0001_0000, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6 async done", {31'd0, done_a}, 32'd0);
    chk("t6 async failed", {31'd0, failed_a}, 32'd0);
    rst_n = 1'b1;
    tick();
    retire(32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("t6 idle after reset", {31'd0, done_a}, 32'd0);
    pulse_start(0);
    retire(32'h0, 1'b1, 5'd2, 32'h0001_0000, 1'b0, 32'h0, 32'h0);
    retire(32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("t6 restart passed", {31'd0, passed_a}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
